// File: rtl/universal_shift_engine_if.sv
// Request/status bundle between a controlling FSM and the shift engine.
// The master side issues operations; the slave side is the engine.
interface universal_shift_engine_if #(
    parameter int N  = 8,
    parameter int CW = 4
) ();
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] amount;
    logic          msb_in;
    logic          lsb_in;
    logic [N-1:0]  p_in;
    logic [N-1:0]  p_out;
    logic          msb_out;
    logic          lsb_out;
    logic          busy;
    logic          done;

    modport master (
        output start, mode, amount, msb_in, lsb_in, p_in,
        input  p_out, msb_out, lsb_out, busy, done
    );

    modport slave (
        input  start, mode, amount, msb_in, lsb_in, p_in,
        output p_out, msb_out, lsb_out, busy, done
    );
endinterface

// File: rtl/universal_shift_engine.sv
// Multi-step universal shift/rotate register with start/busy/done control.
// One 1-bit step of the latched mode is applied per RUN cycle.
module universal_shift_engine #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic clk,
    input  logic reset_n,
    universal_shift_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  reg_q, reg_d;
    logic [N-1:0]  step_v;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          req_shift;

    // One step of the latched mode; serial fills are taken live.
    always_comb begin
        step_v = reg_q;
        unique case (mode_q)
            3'b001:  step_v = {bus.msb_in, reg_q[N-1:1]};
            3'b010:  step_v = {reg_q[N-2:0], bus.lsb_in};
            3'b100:  step_v = {reg_q[0], reg_q[N-1:1]};
            3'b101:  step_v = {reg_q[N-2:0], reg_q[N-1]};
            3'b110:  step_v = {reg_q[N-1], reg_q[N-1:1]};
            default: step_v = reg_q;
        endcase
    end

    always_comb begin
        req_shift = 1'b0;
        unique case (bus.mode)
            3'b001, 3'b010, 3'b100,
            3'b101, 3'b110: req_shift = 1'b1;
            default:        req_shift = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    cnt_d  = bus.amount;
                    busy_d = 1'b1;
                    if (bus.mode == 3'b011) reg_d = bus.p_in;
                    if (bus.mode == 3'b111) reg_d = '0;
                    if (req_shift && (bus.amount != '0)) begin
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                reg_d = step_v;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.p_out   = reg_q;
    assign bus.msb_out = reg_q[N-1];
    assign bus.lsb_out = reg_q[0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_universal_shift_engine.sv
// Scoreboard bench for universal_shift_engine: driver queues expected
// results, a negedge monitor checks them on each done pulse.
module tb_universal_shift_engine;
    localparam int N  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [N-1:0] val;
        int           cyc;
        int           busy;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   compared;
    int   mismatched;
    int   busy_cnt;
    exp_t sb[$];
    logic [N-1:0] model_reg;
    logic [N-1:0] sr_tbl [3];

    universal_shift_engine_if #(.N(N), .CW(CW)) bus ();

    universal_shift_engine #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference result of a whole operation, from the mode definitions.
    function automatic logic [N-1:0] model(input logic [N-1:0] x,
                                           input logic [2:0] m,
                                           input int k,
                                           input logic [N-1:0] pin,
                                           input logic mi,
                                           input logic li);
        logic [N-1:0] ones;
        logic signed [N-1:0] sx;
        int s;
        ones = '1;
        sx = x;
        s = k % N;
        case (m)
            3'd1: return (k >= N) ? {N{mi}}
                         : ((x >> k) | (mi ? ~(ones >> k) : '0));
            3'd2: return (k >= N) ? {N{li}}
                         : ((x << k) | (li ? ~(ones << k) : '0));
            3'd3: return pin;
            3'd4: return (s == 0) ? x : ((x >> s) | (x << (N - s)));
            3'd5: return (s == 0) ? x : ((x << s) | (x >> (N - s)));
            3'd6: return sx >>> k;
            3'd7: return '0;
            default: return x;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("p_out", bus.p_out, e.val);
                    chk("msb_out", bus.msb_out, e.val[N-1]);
                    chk("lsb_out", bus.lsb_out, e.val[0]);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_len", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] m, input int k,
                         input logic [N-1:0] pin,
                         input logic mi, input logic li);
        exp_t e;
        int steps;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.amount = CW'(k);
        bus.p_in   = pin;
        bus.msb_in = mi;
        bus.lsb_in = li;
        steps = (m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) ? k : 0;
        e.val  = model(model_reg, m, k, pin, mi, li);
        e.busy = steps + 1;
        @(posedge clk);
        #1;
        e.cyc = cyc + steps;
        sb.push_back(e);
        model_reg = e.val;
        bus.start  = 1'b0;
        bus.mode   = 3'($urandom);
        bus.amount = CW'($urandom);
        bus.p_in   = N'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", n, 0);
    endtask

    initial begin
        cyc = 0;
        compared = 0;
        mismatched = 0;
        busy_cnt = 0;
        model_reg = '0;
        sr_tbl[0] = 8'hD2;
        sr_tbl[1] = 8'hE9;
        sr_tbl[2] = 8'hF4;

        reset_n    = 1'b0;
        bus.start  = 1'($urandom);
        bus.mode   = 3'($urandom);
        bus.amount = CW'($urandom);
        bus.p_in   = N'($urandom);
        bus.msb_in = 1'($urandom);
        bus.lsb_in = 1'($urandom);
        #3;
        chk("rst_p_out", bus.p_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_msb_lsb", {bus.msb_out, bus.lsb_out}, 0);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        issue(3'd3, 0, 8'hA5, 1'b0, 1'b0);
        chk("load_a5", bus.p_out, 8'hA5);
        wait_idle();

        issue(3'd1, 3, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("sr_step", bus.p_out, sr_tbl[i]);
        end
        wait_idle();

        issue(3'd3, 0, 8'h81, 1'b0, 1'b0);
        wait_idle();
        issue(3'd5, 9, 8'h00, 1'b0, 1'b0);
        wait_idle();
        chk("rol9", bus.p_out, 8'h03);

        issue(3'd3, 0, 8'h90, 1'b0, 1'b0);
        wait_idle();
        issue(3'd6, 2, 8'h00, 1'b0, 1'b0);
        wait_idle();
        chk("asr2", bus.p_out, 8'hE4);
        issue(3'd2, 4, 8'h00, 1'b1, 1'b0);
        wait_idle();
        chk("sl4", bus.p_out, 8'h40);

        issue(3'd1, 5, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        issue(3'd4, 0, 8'h00, 1'b1, 1'b1);
        wait_idle();

        issue(3'd1, 7, 8'h00, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_p_out", bus.p_out, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        sb.delete();
        model_reg = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(3'd3, 0, 8'h3C, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom), int'($urandom_range(0, 15)), N'($urandom),
                  1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.mode  = 3'($urandom);
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/universal_shift_engine.md
# universal_shift_engine

Parametrised multi-step universal shift register, the next generation of the team's 4-bit universal shift register. It adds configurable width and eight operation modes, including rotates and arithmetic shift. A multi-cycle shift-by-amount operation runs under a start/busy/done handshake. It sits between a controlling FSM and a serial or parallel datapath, acting as a shared shift/rotate unit.

## Interface
- N, default 8: register width in bits; N >= 2.
- CW, default 4: width of the `amount` port; 2^CW - 1 is the maximum step count.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only while `busy` = 0.
- mode  in  3  operation code; latched on the accepting edge.
- amount  in  CW  step count for shift/rotate modes; latched on the accepting edge.
- msb_in  in  1  serial fill bit for shift right; sampled live on every step.
- lsb_in  in  1  serial fill bit for shift left; sampled live on every step.
- p_in  in  N  parallel load data; sampled on the accepting edge.
- p_out  out  N  register contents.
- msb_out  out  1  always equal to p_out[N-1].
- lsb_out  out  1  always equal to p_out[0].
- busy  out  1  high while an operation is in progress (RUN or DONE).
- done  out  1  single-cycle completion pulse.

## Operation
- Modes:
  - 000 hold.
  - 001 shift right; msb_in enters bit N-1.
  - 010 shift left; lsb_in enters bit 0.
  - 011 parallel load p_in.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right; the old bit N-1 is replicated.
  - 111 clear to 0.
- FSM states IDLE, RUN, DONE. After reset the FSM is in IDLE.
- IDLE with start = 1 is the accepting edge. mode is latched, and the step counter is loaded with `amount`.
  - Modes 000, 011 and 111 complete on the accepting edge: hold leaves the register unchanged, load writes p_in, clear writes 0. Next state is DONE.
  - Shift/rotate modes (001, 010, 100, 101, 110) with amount = 0: register unchanged, next state DONE.
  - Shift/rotate modes with amount >= 1: register unchanged on the accepting edge, next state RUN.
- RUN: each rising edge performs one 1-bit step of the latched mode and decrements the counter. The edge on which the counter is 1 performs the final step and moves to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Amounts greater than N are executed literally:
  - rotates wrap modulo N;
  - shift right / shift left fill entirely with the serial inputs sampled on the last N steps;
  - arithmetic shift right saturates to all sign bits.
- start is ignored in RUN and DONE and is never queued. Changes to mode, amount and p_in after the accepting edge have no effect.
- msb_in and lsb_in are not latched; each step uses the value present at that edge.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk): p_out = 0, msb_out = 0, lsb_out = 0, busy = 0, done = 0, FSM in IDLE, counter = 0.
- Reset asserted mid-RUN aborts the operation. After release the block is in IDLE; no done pulse is produced.
- Latency, where edge 0 is the accepting edge:
  - Single-cycle modes, or amount = 0: busy high during cycle 1, done high during cycle 1, IDLE at edge 2.
  - amount = k >= 1: busy high for cycles 1..k+1; steps occur on edges 1..k; done high during cycle k+1.
- Back-to-back operation: start held high from the DONE cycle onward is accepted on the first IDLE edge, giving a minimum of one idle cycle between operations.
- msb_out and lsb_out are combinational from the register; they add no latency.

## Test plan
- N=8. Assert reset_n = 0 with arbitrary inputs -> p_out = 0x00, busy = 0, done = 0. Release, then start with mode 011, p_in = 0xA5 -> p_out = 0xA5 after edge 0, busy = done = 1 for one cycle.
- From 0xA5, mode 001, amount 3, msb_in held at 1 -> p_out passes 0xD2, 0xE9, 0xF4 on edges 1–3. busy high for 4 cycles; done pulses in cycle 4 only.
- From 0x81, mode 101, amount 9 -> final p_out = 0x03. msb_out = 0 and lsb_out = 1 at completion.
- From 0x90, mode 110, amount 2 -> 0xE4. Then mode 010, amount 4, lsb_in = 0 -> 0x40.
- Pulse start during RUN with mode 111 -> ignored: the original operation completes unchanged and no second done occurs. Then start with mode 100, amount 0 -> value unchanged, done in the next cycle.
- Start mode 001, amount 7. Drop reset_n after 3 steps -> p_out = 0 and busy = 0 immediately. After release, no done pulse and start is accepted again.
